// File: rtl/johnson_phase_decoder.sv
// Decodes a sampled Johnson count into a registered one-hot/binary phase, wrap pulse and sticky errors.
// Optional stall watchdog: define JOHNSON_PHASE_DEC_STALL_EN.
module johnson_phase_decoder #(
   parameter int WIDTH     = 4,
   parameter int IDX_W     = 3,
   parameter int WRAP_W    = 8,
   parameter int STALL_LIM = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   count_in,
   input  logic               count_vld,
   input  logic               err_clr,
   output logic [2*WIDTH-1:0] phase_onehot,
   output logic [IDX_W-1:0]   phase_idx,
   output logic               phase_vld,
   output logic               wrap_pls,
   output logic [WRAP_W-1:0]  wrap_cnt,
   output logic               locked,
   output logic               err_illegal,
   output logic               err_seq,
   output logic               stall
);
   localparam int               PHASES   = 2 * WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHASES - 1);

   if ((2 ** IDX_W) < PHASES || STALL_LIM < 1) begin : g_param_check
      $error("johnson_phase_decoder: IDX_W too narrow for 2*WIDTH phases or STALL_LIM < 1");
   end

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t           state, state_nxt;
   logic             dec_legal;
   logic [IDX_W-1:0] dec_idx;
   logic [IDX_W-1:0] step_idx;
   logic             is_hold, is_step;
   logic             ill_hit, seq_hit, wrap_hit;

   // Phase k: top k bits set for k <= WIDTH, otherwise top k-WIDTH bits clear and the rest set.
   function automatic logic [WIDTH-1:0] phase_code(input int k);
      logic [WIDTH-1:0] code;
      for (int b = 0; b < WIDTH; b++) begin
         if (k <= WIDTH) code[b] = (WIDTH - 1 - b) < k;
         else            code[b] = (WIDTH - 1 - b) >= (k - WIDTH);
      end
      return code;
   endfunction

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      dec_legal = 1'b0;
      dec_idx   = '0;
      for (int k = 0; k < PHASES; k++) begin
         if (count_in == phase_code(k)) begin
            dec_legal = 1'b1;
            dec_idx   = IDX_W'(k);
         end
      end
   end

   // phase_idx always holds the last legal phase, so it doubles as the previous-sample index.
   assign step_idx = (phase_idx == LAST_IDX) ? '0 : phase_idx + IDX_W'(1);
   assign is_hold  = (dec_idx == phase_idx);
   assign is_step  = (dec_idx == step_idx);

   always_comb begin
      state_nxt = state;
      ill_hit   = 1'b0;
      seq_hit   = 1'b0;
      wrap_hit  = 1'b0;
      if (count_vld) begin
         if (!dec_legal) begin
            ill_hit   = 1'b1;
            state_nxt = SEARCH;
         end else if (state == SEARCH) begin
            state_nxt = LOCKED;
         end else if (is_hold) begin
            state_nxt = LOCKED;
         end else if (is_step) begin
            wrap_hit  = (phase_idx == LAST_IDX);
         end else begin
            seq_hit   = 1'b1;
            state_nxt = SEARCH;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) state <= SEARCH;
      else       state <= state_nxt;
   end

   assign locked = (state == LOCKED);

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_onehot <= (2*WIDTH)'(1);
         phase_idx    <= '0;
         phase_vld    <= 1'b0;
         wrap_pls     <= 1'b0;
         wrap_cnt     <= '0;
         err_illegal  <= 1'b0;
         err_seq      <= 1'b0;
      end else begin
         phase_vld <= count_vld && dec_legal;
         wrap_pls  <= wrap_hit;
         if (count_vld && dec_legal) begin
            phase_idx    <= dec_idx;
            phase_onehot <= (2*WIDTH)'(1) << dec_idx;
         end
         if (wrap_hit) wrap_cnt <= wrap_cnt + WRAP_W'(1);
         // A new error in the same cycle as err_clr keeps the flag set.
         if (ill_hit)      err_illegal <= 1'b1;
         else if (err_clr) err_illegal <= 1'b0;
         if (seq_hit)      err_seq <= 1'b1;
         else if (err_clr) err_seq <= 1'b0;
      end
   end

`ifdef JOHNSON_PHASE_DEC_STALL_EN
   localparam int                 STALL_W   = $clog2(STALL_LIM + 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIM);

   logic [STALL_W-1:0] stall_cnt;
   logic               hold_smp;

   assign hold_smp = count_vld && dec_legal && locked && is_hold;

   // Any sample that is not a locked hold (advance, error, SEARCH) restarts the watchdog.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         stall     <= 1'b0;
      end else if (count_vld) begin
         if (hold_smp) begin
            if (stall_cnt != STALL_MAX)               stall_cnt <= stall_cnt + STALL_W'(1);
            if (stall_cnt >= STALL_MAX - STALL_W'(1)) stall     <= 1'b1;
         end else begin
            stall_cnt <= '0;
            stall     <= 1'b0;
         end
      end
   end
`else
   assign stall = 1'b0;
`endif

endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Downstream consumer of the twisted-ring (Johnson) counter.
- Samples the WIDTH-bit Johnson count and decodes it into a registered one-hot phase, a binary phase index and a wrap pulse.
- Checks that the count sequence is legal and that each step is correct; reports errors on sticky flags.
- Feeds phase-sequenced control logic: strobes, multiplexers, stepper drive.

Parameters:
- WIDTH, 4, Johnson register width; 2*WIDTH phases.
- IDX_W, 3, phase index width; 2**IDX_W >= 2*WIDTH is required.
- WRAP_W, 8, wrap counter width.
- STALL_LIM, 16, stall watchdog limit in samples; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- count_in  in  WIDTH  Johnson count from the upstream counter.
- count_vld  in  1  count_in is sampled on cycles where this is 1.
- err_clr  in  1  clears the sticky error flags.
- phase_onehot  out  2*WIDTH  one-hot decoded phase.
- phase_idx  out  IDX_W  binary phase index, 0..2*WIDTH-1.
- phase_vld  out  1  phase outputs updated this cycle.
- wrap_pls  out  1  one-cycle pulse on the 2W-1 -> 0 transition.
- wrap_cnt  out  WRAP_W  number of wraps, modulo 2**WRAP_W.
- locked  out  1  FSM is in the LOCKED state.
- err_illegal  out  1  sticky: a non-Johnson code was seen.
- err_seq  out  1  sticky: a legal code arrived out of order.
- stall  out  1  watchdog flag (optional feature).

Behaviour:
- Phase map (MSB..LSB, WIDTH=4), phase k = 0..7: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001.
  - For k <= W: the top k bits are 1.
  - For k > W: the top k-W bits are 0, the rest are 1.
  - Every other code is illegal.
- Reset values: phase_onehot = 1 (phase 0), phase_idx = 0, phase_vld = 0, wrap_pls = 0, wrap_cnt = 0, locked = 0, err_illegal = 0, err_seq = 0, stall = 0. FSM enters SEARCH.
- Latency: all outputs are registered, one cycle after the sample (count_vld = 1). With count_vld = 0, phase_vld = 0, wrap_pls = 0, and every other output holds.
- Legal sample:
  - phase_onehot, phase_idx and prev_idx load the decoded phase.
  - phase_vld = 1.
- Illegal sample:
  - Phase outputs hold; phase_vld = 0.
  - err_illegal is set.
  - FSM goes to SEARCH.
- FSM states:
  - SEARCH: the first legal sample seeds prev_idx. Move to LOCKED. No sequence check on this sample.
  - LOCKED, legal sample:
    - Equal to prev_idx (hold): OK, stay LOCKED.
    - Equal to (prev_idx+1) mod 2W: OK, stay LOCKED.
    - Anything else: set err_seq, load the new phase anyway, go to SEARCH.
  - LOCKED, illegal sample: go to SEARCH (as above).
- Wrap: only in LOCKED, on a step from 2W-1 to 0. wrap_pls = 1 for one cycle; wrap_cnt increments and rolls over to 0 after all ones.
- err_clr clears both sticky flags. If an error occurs in the same cycle as err_clr, the set wins. err_clr does not change FSM state.
- Reset mid-operation: every register returns to its reset value on the next edge, regardless of count_vld.

Optional Feature:
- Macro: JOHNSON_PHASE_DEC_STALL_EN.
- Defined:
  - A stall counter counts consecutive LOCKED hold samples (same phase).
  - When the count reaches STALL_LIM, stall = 1. It stays 1 until a phase-advancing sample, SEARCH entry, or reset.
  - An advancing sample clears the counter.
- Undefined: no counter logic; the stall port is tied to 0.

Test Plan:
- Reset, then drive 0000,1000,...,0001,0000 with count_vld = 1 each cycle -> phase_idx 0..7,0 one cycle later; locked = 1 from the second sample; one wrap_pls; wrap_cnt = 1; no errors.
- In LOCKED at phase 3 (1110), drive 1010 -> err_illegal = 1, phase_idx stays 3, phase_vld = 0, locked = 0. Then drive 1111 -> relock at 4. Then err_clr -> err_illegal = 0.
- In LOCKED at phase 2, drive 0111 (phase 5) -> err_seq = 1, phase_idx = 5, locked = 0. Next sample 0011 -> locked = 1, no new error.
- Run 256 full cycles -> wrap_cnt back to 0 with 256 wrap_pls. Repeat samples of the same phase mixed in -> no err_seq.
- Assert reset while LOCKED at phase 6 with err_seq = 1 -> next cycle all outputs at reset values. Toggle count_vld = 0 gaps -> outputs hold, phase_vld = 0.
- With JOHNSON_PHASE_DEC_STALL_EN defined: hold 1100 for 16 samples in LOCKED -> stall = 1 on the 16th. Then 1110 -> stall = 0. Without the macro, stall stays 0 throughout.
